interval_timer: RTL

INTERVAL_TIMER -- requirements
Module: interval_timer

---
 rtl/interval_timer.sv | 116 +++++++++++
 1 files changed

// File: rtl/interval_timer.sv
// Interval timer: a prescaler divides clk down to one tick per PERIOD cycles and an
// elapsed-tick counter runs either free (periodic) or up to a latched limit (one-shot).
module interval_timer #(
   parameter int FREQUENCY = 100_000_000,
   parameter int TICK_HZ   = 1,
   parameter int COUNT_W   = 32
) (
   input  logic               clk,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic               stop_i,
   input  logic               clear_i,
   input  logic               mode_i,
   input  logic [COUNT_W-1:0] limit_i,
   output logic               tick_o,
   output logic [COUNT_W-1:0] elapsed_o,
   output logic               expired_o,
   output logic               running_o
);

   localparam int PERIOD = FREQUENCY / TICK_HZ;
   localparam int PW     = (PERIOD < 2) ? 1 : $clog2(PERIOD);
   localparam logic [PW-1:0] PRESC_MAX = PW'(PERIOD - 1);

   if (PERIOD < 2 || (FREQUENCY % TICK_HZ) != 0) begin : g_bad_period
      $fatal(1, "interval_timer: PERIOD must be >= 2 and FREQUENCY divisible by TICK_HZ");
   end

   typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

   state_t             state_q;
   logic [PW-1:0]      presc_q;
   logic [COUNT_W-1:0] elapsed_q;
   logic [COUNT_W-1:0] limit_q;
   logic               mode_q;
   logic               tick_q;
   logic               expired_q;

   logic [COUNT_W-1:0] elapsed_d;
   logic               launch;
   logic               wrap;

   always_comb begin
      elapsed_d = elapsed_q + 1'b1;
      wrap      = (presc_q == PRESC_MAX);
      // In DONE stop_i is ignored, so only IDLE lets stop_i veto a start.
      launch    = ((state_q == IDLE) && start_i && !stop_i) ||
                  ((state_q == DONE) && start_i);
   end

   always_ff @(posedge clk) begin
      if (rst_i) begin
         state_q   <= IDLE;
         presc_q   <= '0;
         elapsed_q <= '0;
         limit_q   <= '0;
         mode_q    <= 1'b0;
         tick_q    <= 1'b0;
         expired_q <= 1'b0;
      end else if (clear_i) begin
         state_q   <= IDLE;
         presc_q   <= '0;
         elapsed_q <= '0;
         tick_q    <= 1'b0;
         expired_q <= 1'b0;
      end else begin
         tick_q <= 1'b0;
         if (launch) begin
            mode_q    <= mode_i;
            limit_q   <= limit_i;
            presc_q   <= '0;
            elapsed_q <= '0;
            // A one-shot with a zero limit is already satisfied: finish without ticking.
            if (mode_i && (limit_i == '0)) begin
               state_q   <= DONE;
               expired_q <= 1'b1;
            end else begin
               state_q   <= RUN;
               expired_q <= 1'b0;
            end
         end else begin
            case (state_q)
               RUN: begin
                  if (stop_i) begin
                     state_q <= HOLD;
                  end else if (wrap) begin
                     presc_q   <= '0;
                     elapsed_q <= elapsed_d;
                     tick_q    <= 1'b1;
                     if (mode_q && (elapsed_d == limit_q)) begin
                        state_q   <= DONE;
                        expired_q <= 1'b1;
                     end
                  end else begin
                     presc_q <= presc_q + 1'b1;
                  end
               end
               HOLD: begin
                  if (!stop_i && start_i) begin
                     state_q <= RUN;
                  end
               end
               default: begin
                  state_q <= state_q;
               end
            endcase
         end
      end
   end

   assign tick_o    = tick_q;
   assign elapsed_o = elapsed_q;
   assign expired_o = expired_q;
   assign running_o = (state_q == RUN);

endmodule
